// File: rtl/neural_ctrl_pkg.sv
// Shared state encoding and default timing constants for the neural_unit sequencer.
package neural_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIAS,
        ST_STREAM,
        ST_DRAIN,
        ST_FETCH,
        ST_HOLD
    } state_t;

    localparam int DRAIN_CYC_DEF = 4;
    localparam int TIMEOUT_DEF   = 64;

endpackage

// File: rtl/neural_seq_ctrl.sv
// Walks one neural_unit through bias load, beat streaming, pipeline drain and result fetch,
// then offers the compressed result on a valid/ready port.
module neural_seq_ctrl
    import neural_ctrl_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [CNT_W-1:0] cmd_beats_i,
    input  logic [31:0]      cmd_bias_i,
    input  logic [31:0]      cmd_mode_i,
    input  logic [31:0]      cmd_mul_i,
    input  logic [31:0]      cmd_shift_i,
    input  logic             wi_valid_i,
    output logic             wi_ready_o,
    input  logic [31:0]      w_i,
    input  logic [31:0]      x_i,
    output logic             nu_bias_in_o,
    output logic             nu_valid_in_o,
    output logic             nu_get_res_o,
    output logic [31:0]      nu_weights_o,
    output logic [31:0]      nu_input_val_o,
    output logic [31:0]      nu_bias_shift_mode_o,
    output logic [31:0]      nu_out_mul_vals_o,
    output logic [31:0]      nu_out_shift_rl_o,
    input  logic [31:0]      nu_output_val_i,
    input  logic             nu_valid_out_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [31:0]      res_data_o,
    output logic             err_o,
    output logic             busy_o
);

    localparam int DRN_W = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);
    localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_t             r_state;
    state_t             w_next;
    logic               r_live;
    logic [CNT_W-1:0]   r_beats;
    logic [DRN_W-1:0]   r_drn;
    logic [TMO_W-1:0]   r_tmo;
    logic [31:0]        r_bias;
    logic [31:0]        r_mode;
    logic [31:0]        r_mul;
    logic [31:0]        r_shift;
    logic [31:0]        r_res;
    logic               r_err;
    logic               w_cmd_acc;
    logic               w_beat_hs;
    logic               w_last_beat;
    logic               w_tmo_hit;

    assign w_cmd_acc   = cmd_valid_i && cmd_ready_o;
    assign w_beat_hs   = (r_state == ST_STREAM) && wi_valid_i;
    assign w_last_beat = w_beat_hs && (r_beats == CNT_W'(1));
    assign w_tmo_hit   = (r_tmo == TMO_W'(TIMEOUT - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_cmd_acc) w_next = ST_BIAS;
            ST_BIAS:   w_next = (r_beats != '0) ? ST_STREAM : ST_DRAIN;
            ST_STREAM: if (w_last_beat) w_next = ST_DRAIN;
            // One DRAIN cycle minimum, so DRAIN_CYC=0 still spends a cycle here.
            ST_DRAIN:  if (r_drn <= DRN_W'(1)) w_next = ST_FETCH;
            ST_FETCH:  if (nu_valid_out_i || w_tmo_hit) w_next = ST_HOLD;
            ST_HOLD:   if (res_ready_i) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
            r_live  <= 1'b0;
            r_beats <= '0;
            r_drn   <= '0;
            r_tmo   <= '0;
            r_bias  <= '0;
            r_mode  <= '0;
            r_mul   <= '0;
            r_shift <= '0;
            r_res   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_acc) begin
                        r_beats <= cmd_beats_i;
                        r_bias  <= cmd_bias_i;
                        r_mode  <= cmd_mode_i;
                        r_mul   <= cmd_mul_i;
                        r_shift <= cmd_shift_i;
                        r_res   <= '0;
                        r_err   <= 1'b0;
                    end
                end
                ST_BIAS: r_drn <= DRN_W'(DRAIN_CYC);
                ST_STREAM: begin
                    if (w_beat_hs) r_beats <= r_beats - CNT_W'(1);
                    if (w_last_beat) r_drn <= DRN_W'(DRAIN_CYC);
                end
                ST_DRAIN: begin
                    if (r_drn != '0) r_drn <= r_drn - DRN_W'(1);
                    r_tmo <= '0;
                end
                // valid_out has priority over the timeout on the final FETCH cycle.
                ST_FETCH: begin
                    if (nu_valid_out_i) begin
                        r_res <= nu_output_val_i;
                    end else if (w_tmo_hit) begin
                        r_res <= '0;
                        r_err <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready_o          = r_live && (r_state == ST_IDLE);
    assign busy_o               = (r_state != ST_IDLE);
    assign wi_ready_o           = (r_state == ST_STREAM);
    assign nu_valid_in_o        = w_beat_hs;
    assign nu_bias_in_o         = (r_state == ST_BIAS);
    assign nu_get_res_o         = (r_state == ST_FETCH);
    assign res_valid_o          = (r_state == ST_HOLD);
    assign res_data_o           = r_res;
    assign err_o                = r_err;
    assign nu_weights_o         = (r_state == ST_BIAS)   ? r_bias :
                                  (r_state == ST_STREAM) ? w_i    : '0;
    assign nu_input_val_o       = (r_state == ST_STREAM) ? x_i : '0;
    assign nu_bias_shift_mode_o = r_mode;
    assign nu_out_mul_vals_o    = r_mul;
    assign nu_out_shift_rl_o    = r_shift;

endmodule

// File: tb/tb_neural_seq_ctrl.sv
// Scoreboard bench for neural_seq_ctrl: randomised command/beat driver, a neural_unit
// stand-in that answers get_res, and an independent monitor checking against queued expectations.
module tb_neural_seq_ctrl;

    localparam int CNT_W     = 16;
    localparam int DRAIN_CYC = 4;
    localparam int TIMEOUT   = 64;

    typedef struct {
        int          beats;
        logic [31:0] bias;
        logic [31:0] mode;
        logic [31:0] mul;
        logic [31:0] shift;
        logic [31:0] res;
        logic        err;
        int          lat;
    } txn_t;

    logic             clk_i = 1'b0;
    logic             rstn_i;
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic [CNT_W-1:0] cmd_beats_i;
    logic [31:0]      cmd_bias_i, cmd_mode_i, cmd_mul_i, cmd_shift_i;
    logic             wi_valid_i;
    logic             wi_ready_o;
    logic [31:0]      w_i, x_i;
    logic             nu_bias_in_o, nu_valid_in_o, nu_get_res_o;
    logic [31:0]      nu_weights_o, nu_input_val_o;
    logic [31:0]      nu_bias_shift_mode_o, nu_out_mul_vals_o, nu_out_shift_rl_o;
    logic [31:0]      nu_output_val_i;
    logic             nu_valid_out_i;
    logic             res_valid_o;
    logic             res_ready_i;
    logic [31:0]      res_data_o;
    logic             err_o;
    logic             busy_o;

    neural_seq_ctrl #(.CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_beats_i(cmd_beats_i),
        .cmd_bias_i(cmd_bias_i), .cmd_mode_i(cmd_mode_i), .cmd_mul_i(cmd_mul_i),
        .cmd_shift_i(cmd_shift_i),
        .wi_valid_i(wi_valid_i), .wi_ready_o(wi_ready_o), .w_i(w_i), .x_i(x_i),
        .nu_bias_in_o(nu_bias_in_o), .nu_valid_in_o(nu_valid_in_o), .nu_get_res_o(nu_get_res_o),
        .nu_weights_o(nu_weights_o), .nu_input_val_o(nu_input_val_o),
        .nu_bias_shift_mode_o(nu_bias_shift_mode_o), .nu_out_mul_vals_o(nu_out_mul_vals_o),
        .nu_out_shift_rl_o(nu_out_shift_rl_o),
        .nu_output_val_i(nu_output_val_i), .nu_valid_out_i(nu_valid_out_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
        .err_o(err_o), .busy_o(busy_o)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   nsent  = 0;
    int   ndone  = 0;
    bit   mon_off = 1'b0;

    txn_t        txq[$];
    logic [63:0] beatq[$];

    int          m_d    = 0;
    logic [31:0] m_data = '0;
    bit          m_spur = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial forever #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        res_ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1 res_ready_i = ($urandom_range(0, 2) != 0);
        end
    end

    // neural_unit stand-in: valid_out on FETCH cycle m_d, optional junk valid_out elsewhere.
    initial begin
        int fcnt;
        fcnt = 0;
        nu_valid_out_i  = 1'b0;
        nu_output_val_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (!rstn_i || !nu_get_res_o) begin
                fcnt = 0;
                nu_valid_out_i  = rstn_i && m_spur && busy_o && !res_valid_o;
                nu_output_val_i = nu_valid_out_i ? 32'h0000_DEAD : 32'h0;
            end else begin
                nu_valid_out_i  = (fcnt == m_d);
                nu_output_val_i = (fcnt == m_d) ? m_data : ~m_data;
                fcnt++;
            end
        end
    end

    // Monitor
    txn_t cur;
    bit   active  = 1'b0;
    bit   prev_gr = 1'b0;
    int   nb = 0, nv = 0, nr = 0, acc_cyc = 0;

    always @(negedge clk_i) begin
        if (!rstn_i || mon_off) begin
            active  = 1'b0;
            prev_gr = 1'b0;
        end else begin
            if (cmd_valid_i && cmd_ready_o) begin
                if (txq.size() == 0) begin
                    chk("cmd_expected", 32'd0, 32'd1);
                end else begin
                    cur     = txq.pop_front();
                    active  = 1'b1;
                    nb      = 0;
                    nv      = 0;
                    nr      = 0;
                    acc_cyc = cyc;
                end
            end
            if (busy_o) chk("ready_low_when_busy", 32'(cmd_ready_o), 32'd0);
            if (nu_bias_in_o) begin
                nb++;
                chk("bias_word", nu_weights_o, cur.bias);
                chk("err_cleared", 32'(err_o), 32'd0);
                chk("mode_latched", nu_bias_shift_mode_o, cur.mode);
                chk("mul_latched", nu_out_mul_vals_o, cur.mul);
                chk("shift_latched", nu_out_shift_rl_o, cur.shift);
            end
            if (wi_ready_o) nr++;
            if (nu_valid_in_o) begin
                logic [63:0] b;
                nv++;
                if (beatq.size() == 0) begin
                    chk("beat_expected", 32'd0, 32'd1);
                end else begin
                    b = beatq.pop_front();
                    chk("beat_w", nu_weights_o, b[63:32]);
                    chk("beat_x", nu_input_val_o, b[31:0]);
                end
            end
            if (nu_get_res_o && !prev_gr) begin
                chk("beats_before_fetch", 32'(nv), 32'(cur.beats));
                if (cur.lat >= 0) chk("fetch_latency", 32'(cyc - acc_cyc), 32'(cur.lat));
            end
            prev_gr = nu_get_res_o;
            if (res_valid_o && res_ready_i) begin
                if (!active) begin
                    chk("result_expected", 32'd0, 32'd1);
                end else begin
                    chk("res_data", res_data_o, cur.res);
                    chk("res_err", 32'(err_o), 32'(cur.err));
                    chk("bias_pulses", 32'(nb), 32'd1);
                    chk("valid_in_pulses", 32'(nv), 32'(cur.beats));
                    if (cur.beats == 0) chk("no_wi_ready", 32'(nr), 32'd0);
                    chk("mode_held", nu_bias_shift_mode_o, cur.mode);
                    active = 1'b0;
                    ndone++;
                end
            end
        end
    end

    task automatic wait_ready();
        int guard;
        guard = 0;
        do begin
            @(negedge clk_i);
            guard++;
        end while (!cmd_ready_o && guard < 500);
        if (!cmd_ready_o) chk("cmd_ready_wait", 32'd0, 32'd1);
    endtask

    // stall: 0 none, 1 random gaps, 2 two idle cycles before beat index 2
    task automatic run_txn(input int beats, input int stall, input int d,
                           input logic [31:0] data, input bit spur);
        txn_t t;
        int   guard;
        bit   hs;
        wait_ready();
        @(posedge clk_i);
        #1;
        m_d     = d;
        m_data  = data;
        m_spur  = spur;
        t.beats = beats;
        t.bias  = $urandom;
        t.mode  = $urandom;
        t.mul   = $urandom;
        t.shift = $urandom;
        t.err   = (d >= TIMEOUT);
        t.res   = t.err ? 32'h0 : data;
        t.lat   = (stall == 0) ? beats + 2 + DRAIN_CYC : -1;
        txq.push_back(t);
        nsent++;
        cmd_valid_i = 1'b1;
        cmd_beats_i = CNT_W'(beats);
        cmd_bias_i  = t.bias;
        cmd_mode_i  = t.mode;
        cmd_mul_i   = t.mul;
        cmd_shift_i = t.shift;
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
        cmd_beats_i = CNT_W'($urandom);
        cmd_bias_i  = $urandom;
        cmd_mode_i  = $urandom;
        cmd_mul_i   = $urandom;
        cmd_shift_i = $urandom;
        for (int i = 0; i < beats; i++) begin
            int k;
            k = (stall == 1) ? int'($urandom_range(0, 3)) : ((stall == 2 && i == 2) ? 2 : 0);
            if (k > 0) begin
                wi_valid_i = 1'b0;
                repeat (k) begin
                    @(posedge clk_i);
                    #1;
                end
            end
            w_i = $urandom;
            x_i = $urandom;
            beatq.push_back({w_i, x_i});
            wi_valid_i = 1'b1;
            guard = 0;
            do begin
                @(posedge clk_i);
                hs = wi_ready_o;
                guard++;
            end while (!hs && guard < 100);
            #1;
            if (!hs) begin
                chk("beat_accept", 32'd0, 32'd1);
                wi_valid_i = 1'b0;
                return;
            end
        end
        wi_valid_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int guard;
        rstn_i      = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_beats_i = '0;
        cmd_bias_i  = '0;
        cmd_mode_i  = '0;
        cmd_mul_i   = '0;
        cmd_shift_i = '0;
        wi_valid_i  = 1'b0;
        w_i         = '0;
        x_i         = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_res_valid", 32'(res_valid_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_mode", nu_bias_shift_mode_o, 32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("ready_after_reset", 32'(cmd_ready_o), 32'd1);

        run_txn(3, 0, 4, 32'h0000_00A5, 1'b0);
        run_txn(4, 2, 2, $urandom, 1'b0);
        run_txn(0, 0, 3, $urandom, 1'b0);
        run_txn(5, 1, 5, 32'h0000_1234, 1'b1);
        run_txn(2, 0, 500, $urandom, 1'b0);
        run_txn(1, 0, 1, $urandom, 1'b0);
        run_txn(1, 0, TIMEOUT - 1, $urandom, 1'b1);
        run_txn(1, 0, TIMEOUT, $urandom, 1'b0);

        // Asynchronous reset in the middle of a stream
        wait_ready();
        guard = 0;
        while (ndone != nsent && guard < 500) begin
            @(negedge clk_i);
            guard++;
        end
        mon_off = 1'b1;
        @(posedge clk_i);
        #1;
        m_spur      = 1'b0;
        cmd_valid_i = 1'b1;
        cmd_beats_i = CNT_W'(6);
        cmd_bias_i  = $urandom;
        cmd_mode_i  = $urandom;
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
        wi_valid_i  = 1'b1;
        w_i         = $urandom;
        x_i         = $urandom;
        repeat (3) @(posedge clk_i);
        #1;
        chk("midstream_ready", 32'(wi_ready_o), 32'd1);
        #2 rstn_i = 1'b0;
        #1;
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_wi_ready", 32'(wi_ready_o), 32'd0);
        chk("arst_valid_in", 32'(nu_valid_in_o), 32'd0);
        chk("arst_weights", nu_weights_o, 32'd0);
        chk("arst_input", nu_input_val_o, 32'd0);
        chk("arst_mode", nu_bias_shift_mode_o, 32'd0);
        chk("arst_mul_shift", nu_out_mul_vals_o | nu_out_shift_rl_o, 32'd0);
        chk("arst_ctrl", {26'd0, cmd_ready_o, nu_bias_in_o, nu_get_res_o, res_valid_o, err_o, 1'b0}, 32'd0);
        chk("arst_res_data", res_data_o, 32'd0);
        wi_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("arst_held_busy", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        rstn_i  = 1'b1;
        mon_off = 1'b0;
        @(posedge clk_i);
        #1;
        chk("ready_after_arst", 32'(cmd_ready_o), 32'd1);
        run_txn(2, 0, 3, $urandom, 1'b0);

        for (int n = 0; n < 14; n++) begin
            int d;
            case ($urandom_range(0, 5))
                0:       d = TIMEOUT + int'($urandom_range(0, 3));
                1:       d = TIMEOUT - 1;
                default: d = int'($urandom_range(0, 10));
            endcase
            run_txn(int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), d, $urandom,
                    bit'($urandom_range(0, 1)));
        end

        guard = 0;
        while (ndone != nsent && guard < 1000) begin
            @(negedge clk_i);
            guard++;
        end
        chk("all_results_returned", 32'(ndone), 32'(nsent));
        chk("txn_queue_empty", 32'(txq.size()), 32'd0);
        chk("beat_queue_empty", 32'(beatq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
